// File: rtl/counter_mod.sv
// counter_mod: parametrised modulo-N counter with synchronous load, count
// enable, terminal-count flag, one-cycle wrap pulse and sticky overflow.
// Cascade stages by driving the next stage's en from (tc & en).
//
// Parameters:
//   WIDTH    - counter width in bits (1..32)
//   MODULUS  - count range is 0..MODULUS-1 (2..2^WIDTH)
//   SATURATE - 0: wrap at a boundary, 1: hold at the boundary
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous, active-high, highest priority
//   en       - count enable
//   load     - synchronous parallel load, priority over en
//   load_val - value to load (clamped to MODULUS-1)
//   up       - 1 counts up, 0 counts down (only with COUNTER_UPDOWN_EN)
//   clr_ovf  - clears the sticky overflow flag
//   out      - registered count
//   tc       - terminal count, combinational from out and up
//   wrap     - registered one-cycle pulse after a boundary event
//   ovf      - registered sticky overflow flag
//
// Configuration macro: COUNTER_UPDOWN_EN
//   defined   - up port present, down counting supported
//   undefined - up-only counter, no down-count logic

module counter_mod #(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = 256,
    parameter int     SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_UPDOWN_EN
    input  logic             up,
`endif
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // Terminal value held one bit wider so MODULUS = 2^WIDTH compares cleanly.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_OUT = MAX_EXT[WIDTH-1:0];

    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   load_ext;
    logic             at_top;
    logic             at_bound;
    logic             boundary;
    logic [WIDTH-1:0] next_cnt;
    logic [WIDTH-1:0] load_clamped;

    assign cnt_ext  = {1'b0, out};
    assign load_ext = {1'b0, load_val};
    assign at_top   = (cnt_ext == MAX_EXT);

    // Out-of-range load values clamp to the terminal count.
    assign load_clamped = (load_ext > MAX_EXT) ? MAX_OUT : load_val;

`ifdef COUNTER_UPDOWN_EN
    logic at_zero;
    assign at_zero  = (out == '0);
    assign tc       = up ? at_top : at_zero;
    assign at_bound = up ? at_top : at_zero;

    always_comb begin
        next_cnt = out;
        if (up) begin
            if (at_top)
                next_cnt = (SATURATE != 0) ? out : '0;
            else
                next_cnt = out + WIDTH'(1);
        end else begin
            if (at_zero)
                next_cnt = (SATURATE != 0) ? out : MAX_OUT;
            else
                next_cnt = out - WIDTH'(1);
        end
    end
`else
    assign tc       = at_top;
    assign at_bound = at_top;

    // The increment only happens below the terminal value, so it can
    // never carry out of WIDTH bits.
    always_comb begin
        next_cnt = out;
        if (at_top)
            next_cnt = (SATURATE != 0) ? out : '0;
        else
            next_cnt = out + WIDTH'(1);
    end
`endif

    // A boundary event needs a real count edge; load suppresses it.
    assign boundary = en & ~load & at_bound;

    always_ff @(posedge clk) begin
        if (reset) begin
            out  <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                out <= load_clamped;
            end else if (en) begin
                out  <= next_cnt;
                wrap <= at_bound;
            end
            // Set beats clear when both land on the same edge.
            if (boundary)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_mod.sv
// tb_counter_mod: directed testbench for counter_mod with WIDTH=4,
// MODULUS=10. One instance wraps (SATURATE=0), a second saturates
// (SATURATE=1). Down-count vectors are built only with COUNTER_UPDOWN_EN.

module tb_counter_mod;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       clr_ovf;
    logic       up;
    logic [3:0] out;
    logic       tc;
    logic       wrap;
    logic       ovf;

    logic       en_s;
    logic       load_s;
    logic [3:0] load_val_s;
    logic       clr_ovf_s;
    logic [3:0] out_s;
    logic       tc_s;
    logic       wrap_s;
    logic       ovf_s;

    int total;
    int bad;

    counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
`ifdef COUNTER_UPDOWN_EN
        .up       (up),
`endif
        .clr_ovf  (clr_ovf),
        .out      (out),
        .tc       (tc),
        .wrap     (wrap),
        .ovf      (ovf)
    );

    counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
        .clk      (clk),
        .reset    (reset),
        .en       (en_s),
        .load     (load_s),
        .load_val (load_val_s),
`ifdef COUNTER_UPDOWN_EN
        .up       (up),
`endif
        .clr_ovf  (clr_ovf_s),
        .out      (out_s),
        .tc       (tc_s),
        .wrap     (wrap_s),
        .ovf      (ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic ld,
                                 input logic [3:0] lv, input logic e,
                                 input logic c);
        reset    = r;
        load     = ld;
        load_val = lv;
        en       = e;
        clr_ovf  = c;
        tick();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        en         = 1'b0;
        load       = 1'b0;
        load_val   = 4'd0;
        clr_ovf    = 1'b0;
        up         = 1'b1;
        en_s       = 1'b0;
        load_s     = 1'b0;
        load_val_s = 4'd0;
        clr_ovf_s  = 1'b0;

        // Reset held two cycles with en high
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("rst_out",  out,  0);
        checkOutput("rst_wrap", wrap, 0);
        checkOutput("rst_ovf",  ovf,  0);
        checkOutput("rst_tc",   tc,   0);
        checkOutput("rst_out_s", out_s, 0);
        checkOutput("rst_ovf_s", ovf_s, 0);

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("post_rst_cnt", out, 3);

        // Full wrap-up sequence from zero
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            checkOutput("wrap_out",  out,  i % 10);
            checkOutput("wrap_tc",   tc,   (i == 9) ? 1 : 0);
            checkOutput("wrap_pul",  wrap, (i == 10) ? 1 : 0);
            checkOutput("wrap_ovf",  ovf,  (i == 10) ? 1 : 0);
        end

        // Load clamp beats en, and load is not a boundary event
        applyStimulus(1'b0, 1'b1, 4'd12, 1'b1, 1'b0);
        checkOutput("clamp_out",  out,  9);
        checkOutput("clamp_wrap", wrap, 0);
        checkOutput("clamp_ovf",  ovf,  1);
        applyStimulus(1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
        checkOutput("load4_out", out, 4);

        // Idle edge holds count, wrap stays low
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("hold_out",  out,  4);
        checkOutput("hold_wrap", wrap, 0);

        // Clear colliding with a wrap: set wins, clear applies next edge
        applyStimulus(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("coll_out",  out,  0);
        checkOutput("coll_wrap", wrap, 1);
        checkOutput("coll_ovf",  ovf,  1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("clr_out",  out,  1);
        checkOutput("clr_wrap", wrap, 0);
        checkOutput("clr_ovf",  ovf,  0);

`ifdef COUNTER_UPDOWN_EN
        // Down wrap from 1
        applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        up = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("dn_out0",  out,  0);
        checkOutput("dn_tc0",   tc,   1);
        checkOutput("dn_wrap0", wrap, 0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("dn_out9",  out,  9);
        checkOutput("dn_wrap9", wrap, 1);
        checkOutput("dn_tc9",   tc,   0);
        checkOutput("dn_ovf",   ovf,  1);
        up = 1'b1;
        #1;
        checkOutput("up_tc9", tc, 1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("dn_wrap_end", wrap, 0);
`endif

        // Reset overrides simultaneous load, en and clr_ovf
        applyStimulus(1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
        checkOutput("rst_mid_out", out, 0);
        checkOutput("rst_mid_ovf", ovf, 0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Saturating instance: hold at 9, wrap high on every boundary edge
        load_s = 1'b1; load_val_s = 4'd8;
        tick();
        checkOutput("sat_load", out_s, 8);
        load_s = 1'b0; en_s = 1'b1;
        tick();
        checkOutput("sat_out1",  out_s,  9);
        checkOutput("sat_wrap1", wrap_s, 0);
        checkOutput("sat_ovf1",  ovf_s,  0);
        tick();
        checkOutput("sat_out2",  out_s,  9);
        checkOutput("sat_wrap2", wrap_s, 1);
        checkOutput("sat_ovf2",  ovf_s,  1);
        tick();
        checkOutput("sat_out3",  out_s,  9);
        checkOutput("sat_wrap3", wrap_s, 1);
        en_s = 1'b0;
        tick();
        checkOutput("sat_idle_wrap", wrap_s, 0);
        checkOutput("sat_idle_out",  out_s,  9);
        checkOutput("sat_idle_ovf",  ovf_s,  1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
